gen_waddr: RTL and testbench
============================

GEN_WADDR -- requirements
Module: gen_waddr

Interface
REQ-001 Parameter: AFULL_THR, default 12, almost-full threshold in entries (1..2**`ADDRSIZE).
REQ-002 Width from global define `ADDRSIZE, default 4; FIFO depth = 2**`ADDRSIZE; `ADDRSIZE >= 2.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; ports named wclk and wrst_n.
REQ-004 wclk  input  1  write-domain clock, rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 winc  input  1  write request, one entry per cycle while high.
REQ-007 wq2_rptr  input  `ADDRSIZE+1  read pointer (Gray), already synchronized 2 wclk.
REQ-008 waddr  output  `ADDRSIZE  binary write address to the dual-port RAM.
REQ-009 wptr  output  `ADDRSIZE+1  registered Gray write pointer, crossed to the read domain.
REQ-010 wfull  output  1  registered full flag.
REQ-011 wafull  output  1  registered almost-full flag.
REQ-012 wlevel  output  `ADDRSIZE+1  registered fill level, 0..2**`ADDRSIZE.
REQ-013 wovf  output  1  sticky overflow error.

Function
REQ-014 Internal binary pointer wbin (`ADDRSIZE+1 bits); wbin_next = wbin + (winc && !wfull), modulo 2**(`ADDRSIZE+1).
REQ-015 waddr shall equal wbin[`ADDRSIZE-1:0]; RAM write enable is winc && !wfull, owned by the RAM wrapper.
REQ-016 wptr shall be registered gray(wbin_next) = wbin_next ^ (wbin_next >> 1); exactly one bit changes per accepted write.
REQ-017 wfull shall be registered: gray(wbin_next) == {~wq2_rptr[top two bits], wq2_rptr[remaining bits]}.
REQ-018 wfull asserts in the same edge as the write filling the last entry, so a write in the next cycle is blocked.
REQ-019 wfull deasserts no earlier than the first wclk edge after wq2_rptr advances (pessimistic; never optimistic).
REQ-020 winc while wfull: pointer, wptr, waddr unchanged; wovf set at that edge and held.
REQ-021 Wrap-around: wbin rolls from all-ones to zero; waddr wraps at depth; full/empty distinction kept by MSB.
REQ-022 wlevel shall be registered wbin_next - gray2bin(wq2_rptr), `ADDRSIZE+1 bits modulo arithmetic.
REQ-023 wafull shall be registered (wlevel_next >= AFULL_THR); wafull is high whenever wfull is high.
REQ-024 Simultaneous accepted write and wq2_rptr change: both reflected in the same edge's wlevel/wfull.

Reset
REQ-025 wrst_n low shall asynchronously clear wbin, wptr, wlevel, wfull, wafull, wovf to 0; waddr = 0.
REQ-026 Reset mid-burst discards pointer state; first accepted write after release uses waddr 0.
REQ-027 Reset release is synchronous to wclk (externally synchronized deassertion).

Configuration
REQ-028 Macro ASYN_FIFO_WAFULL_EN: defined -> wlevel, wafull, gray2bin logic present as above.
REQ-029 Not defined -> wlevel driven 0, wafull equal to wfull, no gray-to-binary logic synthesized; REQ-014..021 unchanged.

Structure
REQ-030 `ADDRSIZE and AFULL_THR default live in the shared asyn_fifo defines file used by the read-side generator.
REQ-031 One sub-module gray2bin (parameterized width, combinational XOR prefix) instantiated for wq2_rptr.

Verification (ADDRSIZE=4, AFULL_THR=12)
REQ-032 Reset, then 16 writes with wq2_rptr=0 -> waddr 0..15, wfull high after 16th write, wptr=5'b11000, wlevel=16.
REQ-033 17th winc while full -> waddr stays 0, wptr unchanged, wovf=1 and stays 1 until wrst_n low.
REQ-034 Full, then wq2_rptr=gray(1)=5'b00001 -> wfull low next wclk edge, wlevel=15, wafull still high.
REQ-035 Write 12 entries, rptr=0 -> wafull rises at 12th write edge; wafull low at 11 entries.
REQ-036 40 writes with matching rptr trailing by 3 -> wbin wraps at 32, wptr single-bit change each write, wfull never high.
REQ-037 wrst_n low asynchronously mid-burst (no clock edge) -> all outputs 0 immediately; next accepted write at waddr 0.

Source files
------------

// File: rtl/gen_waddr_pkg.sv
// ---------------------------------------------------------------------------
// gen_waddr_pkg
// Shared asyn_fifo definitions for the write-side and read-side pointer
// generators. This file is the single home of the global `ADDRSIZE and of
// the almost-full threshold default, so both clock domains agree on depth.
//
// Defines (overridable from the command line):
//   `ADDRSIZE           address width, FIFO depth = 2**`ADDRSIZE (>= 2)
//   `AFULL_THR_DEFAULT  default almost-full threshold in entries
// Package contents:
//   ADDR_W, PTR_W, DEPTH, AFULL_THR_DEF, ptr_t, bin2gray()
// ---------------------------------------------------------------------------
`ifndef ADDRSIZE
`define ADDRSIZE 4
`endif

`ifndef AFULL_THR_DEFAULT
`define AFULL_THR_DEFAULT 12
`endif

package gen_waddr_pkg;

  localparam int ADDR_W        = `ADDRSIZE;
  localparam int PTR_W         = ADDR_W + 1;
  localparam int DEPTH         = 1 << ADDR_W;
  localparam int AFULL_THR_DEF = `AFULL_THR_DEFAULT;

  // Pointers carry one extra MSB so full and empty remain distinguishable.
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gen_waddr_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary decoder (XOR prefix from the MSB down).
// Only needed for the fill-level path, so the module exists only when
// ASYN_FIFO_WAFULL_EN is defined; otherwise no decoder is built at all.
//
// Parameters:
//   W       code width
// Ports:
//   gray_i  input  [W-1:0]  Gray-coded value
//   bin_o   output [W-1:0]  binary equivalent
// ---------------------------------------------------------------------------
`ifdef ASYN_FIFO_WAFULL_EN
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic acc;

  always_comb begin
    bin_o = '0;
    acc   = 1'b0;
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (int i = W - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule
`endif

// File: rtl/gen_waddr.sv
// ---------------------------------------------------------------------------
// gen_waddr
// Write-side pointer/flag generator of an asynchronous FIFO. Keeps a binary
// write pointer, exports it Gray-coded for the read domain, and derives a
// registered full flag from the synchronized read pointer. A write attempt
// while full is dropped and latches a sticky overflow flag.
//
// Optional feature (macro ASYN_FIFO_WAFULL_EN):
//   defined     -> registered fill level and almost-full flag
//   not defined -> wlevel tied to 0, wafull mirrors wfull, no Gray decoder
//
// Parameters:
//   AFULL_THR  almost-full threshold in entries (1 .. 2**`ADDRSIZE)
// Ports:
//   wclk      input   1            write clock, rising edge
//   wrst_n    input   1            asynchronous active-low reset
//   winc      input   1            write request, one entry per cycle
//   wq2_rptr  input   `ADDRSIZE+1  Gray read pointer, synchronized to wclk
//   waddr     output  `ADDRSIZE    binary RAM write address
//   wptr      output  `ADDRSIZE+1  registered Gray write pointer
//   wfull     output  1            registered full flag
//   wafull    output  1            registered almost-full flag
//   wlevel    output  `ADDRSIZE+1  registered fill level
//   wovf      output  1            sticky overflow flag
// ---------------------------------------------------------------------------
module gen_waddr
  import gen_waddr_pkg::*;
#(
  parameter int AFULL_THR = AFULL_THR_DEF
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [`ADDRSIZE:0]  wq2_rptr,
  output logic [`ADDRSIZE-1:0] waddr,
  output logic [`ADDRSIZE:0]  wptr,
  output logic                wfull,
  output logic                wafull,
  output logic [`ADDRSIZE:0]  wlevel,
  output logic                wovf
);

  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_thr
    $error("gen_waddr: AFULL_THR outside 1..2**ADDRSIZE");
  end

  logic wen;
  ptr_t wbin_q, wbin_d;
  ptr_t wptr_q, wptr_d;
  logic wfull_q, wfull_d;
  logic wovf_q, wovf_d;

  assign wen = winc && !wfull_q;

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wen};
    wptr_d  = bin2gray(wbin_d);
    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that means the top two bits inverted.
    wfull_d = (wptr_d == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
    wovf_d  = wovf_q || (winc && wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
  end

  assign waddr = wbin_q[ADDR_W-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign wovf  = wovf_q;

`ifdef ASYN_FIFO_WAFULL_EN
  localparam ptr_t AFULL_LVL = ptr_t'(AFULL_THR);

  ptr_t rbin;
  ptr_t wlevel_q, wlevel_d;
  logic wafull_q, wafull_d;

  gray2bin #(
    .W(PTR_W)
  ) u_rptr_g2b (
    .gray_i(wq2_rptr),
    .bin_o (rbin)
  );

  // Level uses the next write pointer so an accepted write and a read
  // pointer advance in the same cycle both show up at this edge.
  assign wlevel_d = wbin_d - rbin;
  assign wafull_d = (wlevel_d >= AFULL_LVL);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      wafull_q <= 1'b0;
    end else begin
      wlevel_q <= wlevel_d;
      wafull_q <= wafull_d;
    end
  end

  assign wlevel = wlevel_q;
  assign wafull = wafull_q;
`else
  assign wlevel = '0;
  assign wafull = wfull_q;
`endif

endmodule

// File: tb/tb_gen_waddr.sv
`ifndef ADDRSIZE
`define ADDRSIZE 4
`endif

module tb_gen_waddr;

  localparam int AW   = `ADDRSIZE;
  localparam int PW   = AW + 1;
  localparam int THR  = 12;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic [PW-1:0] wq2_rptr = '0;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          wafull;
  logic [PW-1:0] wlevel;
  logic          wovf;

  gen_waddr #(
    .AFULL_THR(THR)
  ) dut (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .waddr   (waddr),
    .wptr    (wptr),
    .wfull   (wfull),
    .wafull  (wafull),
    .wlevel  (wlevel),
    .wovf    (wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] wlevel;
    logic          wfull;
    logic          wafull;
    logic          wovf;
  } exp_t;

  exp_t sbq[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [PW-1:0] m_bin;
  logic [PW-1:0] m_lvl;
  logic          m_full;
  logic          m_afull;
  logic          m_ovf;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin   = '0;
    m_lvl   = '0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic push_model();
    exp_t e;
    e.waddr = m_bin[AW-1:0];
    e.wptr  = b2g(m_bin);
    e.wfull = m_full;
    e.wovf  = m_ovf;
`ifdef ASYN_FIFO_WAFULL_EN
    e.wlevel = m_lvl;
    e.wafull = m_afull;
`else
    e.wlevel = '0;
    e.wafull = m_full;
`endif
    sbq.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_waddr"},  32'(waddr),  32'(e.waddr));
      check({tag, "_wptr"},   32'(wptr),   32'(e.wptr));
      check({tag, "_wfull"},  32'(wfull),  32'(e.wfull));
      check({tag, "_wafull"}, 32'(wafull), 32'(e.wafull));
      check({tag, "_wlevel"}, 32'(wlevel), 32'(e.wlevel));
      check({tag, "_wovf"},   32'(wovf),   32'(e.wovf));
    end
  endtask

  // One clock of stimulus: drive on the falling edge, update the model at the
  // rising edge, compare 1 time unit later.
  task automatic step(input logic w, input logic [PW-1:0] rg, input string tag);
    logic acc;
    @(negedge wclk);
    winc     = w;
    wq2_rptr = rg;
    @(posedge wclk);
    acc     = w && !m_full;
    m_ovf   = m_ovf || (w && m_full);
    m_bin   = m_bin + PW'(acc);
    m_lvl   = m_bin - g2b(rg);
    m_full  = (m_lvl == PW'(1 << AW));
    m_afull = (m_lvl >= PW'(THR));
    push_model();
    #1;
    pop_check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] prev_ptr;
    logic [PW-1:0] rg;

    // Reset state
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    push_model();
    pop_check("reset");
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill 16 entries with the read pointer parked at 0
    for (int i = 0; i < 16; i++) begin
      step(1'b1, '0, "fill");
`ifdef ASYN_FIFO_WAFULL_EN
      if (i == 10) check("afull_at_11", 32'(wafull), 32'd0);
      if (i == 11) check("afull_at_12", 32'(wafull), 32'd1);
`else
      if (i == 11) check("afull_at_12", 32'(wafull), 32'd0);
`endif
    end
    check("full_wptr", 32'(wptr), 32'b11000);
    check("full_flag", 32'(wfull), 32'd1);
`ifdef ASYN_FIFO_WAFULL_EN
    check("full_level", 32'(wlevel), 32'd16);
`endif

    // Write while full: dropped, overflow latched
    step(1'b1, '0, "ovf");
    check("ovf_waddr", 32'(waddr), 32'd0);
    check("ovf_wptr", 32'(wptr), 32'b11000);
    check("ovf_flag", 32'(wovf), 32'd1);

    // One read observed: full drops, level 15, almost-full remains
    step(1'b0, 5'b00001, "drain1");
    check("drain_full", 32'(wfull), 32'd0);
`ifdef ASYN_FIFO_WAFULL_EN
    check("drain_level", 32'(wlevel), 32'd15);
    check("drain_afull", 32'(wafull), 32'd1);
`endif
    repeat (3) step(1'b0, 5'b00001, "hold");
    check("ovf_sticky", 32'(wovf), 32'd1);

    // Reset between edges clears everything at once
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    model_reset();
    push_model();
    pop_check("rst1");
    @(negedge wclk);
    wrst_n   = 1'b1;
    wq2_rptr = '0;

    // 40 writes, read pointer trailing by 3: wraps past 32, never full
    rg = '0;
    for (int k = 0; k < 40; k++) begin
      rg       = (k >= 3) ? b2g(PW'(k - 3)) : '0;
      prev_ptr = wptr;
      step(1'b1, rg, "wrap");
      check("wrap_1bit", 32'($countones(wptr ^ prev_ptr)), 32'd1);
      check("wrap_nofull", 32'(wfull), 32'd0);
    end
    check("wrap_waddr", 32'(waddr), 32'd8);

    // Mid-burst asynchronous reset
    repeat (3) step(1'b1, rg, "burst");
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    model_reset();
    push_model();
    pop_check("async_rst");
    @(posedge wclk);
    #1;
    push_model();
    pop_check("rst_hold");
    @(negedge wclk);
    wrst_n   = 1'b1;
    winc     = 1'b0;
    wq2_rptr = '0;
    step(1'b0, '0, "post_idle");
    check("post_waddr0", 32'(waddr), 32'd0);
    step(1'b1, '0, "post_wr");
    check("post_waddr1", 32'(waddr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
